mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Bus controller between the processor core's memory port and the shared external 8-bit `mem_io` bus. It turns a single-cycle core request (address, write data, direction) into a multiplexed address-phase / data-phase bus cycle. It honours memory wait states through `mem_rdy` and returns read data with a one-cycle acknowledge. It owns the `mem_io` tri-state driver and the `rw_mem` direction line, so the core never drives the pins directly.

## Interface

Parameters:
- `TIMEOUT`, 15: maximum DATA-phase cycles to wait for `mem_rdy` before aborting; range 1..255.

Ports:
- `dbg_clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: core request; sampled only in IDLE.
- `we` in 1: request direction, 1 = write, 0 = read; sampled with `req`.
- `addr` in 8: request address; sampled with `req`.
- `wdata` in 8: write data; sampled with `req`.
- `rdata` out 8: read data; holds the last captured value.
- `ack` out 1: one-cycle pulse when the transaction completes.
- `err` out 1: one-cycle pulse coincident with `ack` when the transaction timed out.
- `busy` out 1: high from the cycle after acceptance through DONE.
- `mem_io` inout 8: multiplexed address/data bus.
- `rw_mem` out 1: 1 = controller drives `mem_io`; 0 = `mem_io` is high-Z.
- `mem_ale` out 1: address latch strobe.
- `mem_we` out 1: write strobe.
- `mem_rdy` in 1: memory ready; sampled only in DATA.

## Operation

- Moore FSM with states IDLE, ADDR, TURN, DATA and DONE. All bus outputs decode from the registered state and latched request.
- Reset values: state IDLE; `rdata` 8'h00; `ack`, `err`, `busy`, `rw_mem`, `mem_ale` and `mem_we` all 0; `mem_io` high-Z; wait counter 0.
- **IDLE:** if `req` is high, latch `addr`, `we` and `wdata`, then go to ADDR.
- **ADDR:** `rw_mem`=1, `mem_io`=latched addr, `mem_ale`=1.
  - Write: go to DATA.
  - Read: go to TURN.
- **TURN** (reads only): `rw_mem`=0, bus released for one cycle to avoid contention. Go to DATA.
- **DATA, write:** `rw_mem`=1, `mem_io`=latched wdata, `mem_we`=1.
- **DATA, read:** `rw_mem`=0.
- **DATA, every cycle:** the wait counter increments.
  - If `mem_rdy`=1: for a read, capture `mem_io` into `rdata`. Go to DONE.
  - Else if the counter equals TIMEOUT-1: set the error flag. For a read, load `rdata`=8'hFF. Go to DONE.
- **DONE:** `ack`=1, `err` = error flag, `rw_mem`=0. Clear the counter and error flag, then go to IDLE.
- While busy, `req` and the core inputs are ignored. They are not queued.
- `mem_rdy` outside DATA is ignored.
- `rw_mem`=0 in every state except ADDR and write-DATA.
- Reset asserted mid-transaction:
  - The transaction is aborted and all outputs return to reset values immediately.
  - No `ack` is issued, and `rdata` returns to 8'h00.

## Timing

- `req` is accepted at edge 0 and `busy` rises after edge 0.
- Write with `mem_rdy` already high:
  - ADDR in cycle 1, DATA in cycle 2, DONE in cycle 3.
  - `ack` is high in cycle 3, so latency is 3 cycles.
- Read with `mem_rdy` already high:
  - ADDR in cycle 1, TURN in cycle 2, DATA in cycle 3, DONE in cycle 4.
  - `ack` is high in cycle 4, so latency is 4 cycles.
- Each cycle with `mem_rdy` low in DATA adds one cycle, up to TIMEOUT cycles total in DATA.
- A read captures `mem_io` at the rising edge that ends the DATA cycle in which `mem_rdy`=1.
- After DONE the controller returns to IDLE for at least one cycle, so back-to-back requests are spaced by at least 1 idle cycle.
- `mem_ale` and `mem_we` are each exactly one cycle per zero-wait transaction. `mem_we` stays high for every DATA cycle of a write.

## Configuration

- `MEM_BUS_TIMEOUT_EN` defined:
  - The wait counter and timeout abort are compiled in, as described above.
- `MEM_BUS_TIMEOUT_EN` undefined:
  - There is no counter, and DATA waits indefinitely for `mem_rdy`.
  - `err` is tied to 0 and `rdata` is never forced to 8'hFF.
  - `TIMEOUT` is unused.

## Test plan

- Reset then idle: `rst` pulse with `req`=0 -> every output at its reset value, `mem_io` high-Z, `busy`=0 indefinitely.
- Zero-wait write: `req`=1, `we`=1, `addr`=8'h3C, `wdata`=8'hA5, `mem_rdy`=1 -> cycle 1 `mem_io`=8'h3C with `mem_ale`=1; cycle 2 `mem_io`=8'hA5 with `mem_we`=1; cycle 3 `ack`=1, `err`=0.
- Read with 2 wait states: `addr`=8'h10; memory drives 8'h5A and raises `mem_rdy` on the 3rd DATA cycle -> TURN has `rw_mem`=0; `ack` in cycle 6; `rdata`=8'h5A.
- Timeout (macro defined, TIMEOUT=15): read with `mem_rdy` held at 0 -> exactly 15 DATA cycles, then `ack`=1 and `err`=1 for one cycle, `rdata`=8'hFF; without the macro, no `ack` after 100 cycles.
- Reset mid-transaction: assert `rst` during DATA of a write -> `rw_mem`=0, `mem_we`=0, `mem_io` high-Z the same cycle, no `ack`; a following read completes normally.
- Back-to-back requests: hold `req`=1 continuously for two zero-wait writes -> second ADDR begins exactly one IDLE cycle after the first DONE; `req` during busy is neither queued nor duplicated.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - core-side request/response bundle for mem_bus_ctrl
//
// Purpose: groups the processor core's memory-port handshake into one
// interface so the core and the bus controller connect through a single port.
//
// Signals:
//   req    core -> ctrl  request strobe, sampled only while the controller is idle
//   we     core -> ctrl  direction, 1 = write, 0 = read
//   addr   core -> ctrl  8-bit request address
//   wdata  core -> ctrl  8-bit write data
//   rdata  ctrl -> core  last captured read data
//   ack    ctrl -> core  one-cycle completion pulse
//   err    ctrl -> core  one-cycle timeout pulse, coincident with ack
//   busy   ctrl -> core  transaction in flight
//
// Modports: master = core side, slave = bus controller side.

interface mem_bus_ctrl_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       err;
  logic       busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multiplexed 8-bit memory bus controller
//
// Purpose: turns a single-cycle core request into an address phase followed
// by a data phase on the shared mem_io bus, honouring wait states via
// mem_rdy and returning read data with a one-cycle ack. Owns the mem_io
// tri-state driver and the rw_mem direction line.
//
// Ports:
//   dbg_clk  in     system clock, rising edge
//   rst      in     asynchronous active-high reset
//   bus      slave  core request/response (req/we/addr/wdata/rdata/ack/err/busy)
//   mem_io   inout  multiplexed address/data bus, high-Z unless rw_mem=1
//   rw_mem   out    1 = controller drives mem_io
//   mem_ale  out    address latch strobe
//   mem_we   out    write strobe, high for every DATA cycle of a write
//   mem_rdy  in     memory ready, sampled only in DATA
//
// Parameter: TIMEOUT (1..255) - max DATA cycles before aborting.
// Build option: MEM_BUS_TIMEOUT_EN - when defined, compiles in the DATA-phase
// wait counter and timeout abort; otherwise DATA waits indefinitely for
// mem_rdy and err is never raised.

module mem_bus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic               dbg_clk,
  input  logic               rst,
  mem_bus_ctrl_if.slave      bus,
  inout  wire  [7:0]         mem_io,
  output logic               rw_mem,
  output logic               mem_ale,
  output logic               mem_we,
  input  logic               mem_rdy
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_bus_ctrl: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_DATA,
    S_DONE
  } state_t;

  state_t     state;
  logic       we_q;
  logic [7:0] wdata_q;
  logic [7:0] io_out;   // value presented on mem_io while rw_mem is high

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
`endif

  // Outputs are registered: each transition loads the values the next state
  // presents, so the bus pins never glitch from combinational decode.
  assign mem_io = rw_mem ? io_out : 8'hzz;

  always_ff @(posedge dbg_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      io_out    <= 8'h00;
      rw_mem    <= 1'b0;
      mem_ale   <= 1'b0;
      mem_we    <= 1'b0;
      bus.rdata <= 8'h00;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt       <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            wdata_q  <= bus.wdata;
            io_out   <= bus.addr;
            rw_mem   <= 1'b1;
            mem_ale  <= 1'b1;
            bus.busy <= 1'b1;
            state    <= S_ADDR;
          end
        end

        S_ADDR: begin
          mem_ale <= 1'b0;
          if (we_q) begin
            io_out <= wdata_q;
            mem_we <= 1'b1;
            state  <= S_DATA;
          end else begin
            // Release the bus for a cycle before the memory starts driving.
            rw_mem <= 1'b0;
            state  <= S_TURN;
          end
        end

        S_TURN: begin
          state <= S_DATA;
        end

        S_DATA: begin
          if (mem_rdy) begin
            if (!we_q) begin
              bus.rdata <= mem_io;
            end
            rw_mem  <= 1'b0;
            mem_we  <= 1'b0;
            bus.ack <= 1'b1;
            state   <= S_DONE;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          // cnt counts completed DATA cycles, so cnt == TIMEOUT-1 marks the
          // last permitted DATA cycle.
          else if (cnt == CNT_LAST) begin
            if (!we_q) begin
              bus.rdata <= 8'hFF;
            end
            rw_mem  <= 1'b0;
            mem_we  <= 1'b0;
            bus.ack <= 1'b1;
            bus.err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end

        S_DONE: begin
          bus.ack  <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt      <= 8'h00;
`endif
          state    <= S_IDLE;
        end

        default: begin
          rw_mem   <= 1'b0;
          mem_ale  <= 1'b0;
          mem_we   <= 1'b0;
          bus.ack  <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
